// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin search: first set req bit strictly after last_owner, wrapping.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk the N_REQ candidates starting at last_owner+1; the first hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % N_REQ);
      if (!valid && req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between N_REQ byte requesters, optionally holding the
// grant for a whole line (up to LOCK_MAX bytes).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; round-robin pick among pending requests
// SEND  | byte presented to uart_tx, waiting for tx_ready
// GAP   | byte taken, ack pulsing; continue the line or release grant
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LINE_LOCK = 1,
  parameter int LOCK_MAX  = 128
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_req,
  output logic [7:0]         tx_data,
  input  logic               tx_ready
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(N_REQ - 1);
  localparam logic [7:0]       BURST_MAX = 8'(LOCK_MAX);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [7:0]       burst_q, burst_d;

  logic [7:0]       data_arr [N_REQ];
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             hold_line;

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_arr[i] = data[8*i +: 8];
  end

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  // tx_data_q still holds the byte just sent while in GAP.
  assign hold_line = (LINE_LOCK != 0) && (tx_data_q != ASCII_LF) &&
                     (burst_q < BURST_MAX) && req[owner_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    tx_req_d     = tx_req_q;
    tx_data_d    = tx_data_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    unique case (state_q)
      IDLE: begin
        tx_req_d = 1'b0;
        grant_d  = '0;
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          tx_data_d         = data_arr[pick_idx];
          tx_req_d          = 1'b1;
          burst_d           = 8'd1;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_req_d       = 1'b0;
          ack_d[owner_q] = 1'b1;
          state_d        = GAP;
        end
      end
      GAP: begin
        if (hold_line) begin
          tx_data_d = data_arr[owner_q];
          tx_req_d  = 1'b1;
          burst_d   = burst_q + 8'd1;
          state_d   = SEND;
        end else begin
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      owner_q      <= '0;
      last_owner_q <= OWNER_RST;
      burst_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: instance 0 locks lines (LOCK_MAX=4), instance 1
// re-arbitrates every byte. Predicted (grant, byte) pairs go into a queue
// and are compared when the uart_tx model takes each byte.
module tb_uart_tx_arb;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  logic [3:0]  req_v      [2];
  logic [31:0] data_v     [2];
  logic [3:0]  ack_v      [2];
  logic [3:0]  grant_v    [2];
  logic        tx_req_v   [2];
  logic [7:0]  tx_data_v  [2];
  logic        tx_ready_v [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_arb #(
      .N_REQ     (4),
      .LINE_LOCK ((g == 0) ? 1 : 0),
      .LOCK_MAX  ((g == 0) ? 4 : 128)
    ) u_dut (
      .clk      (clk),
      .reset_   (reset_),
      .req      (req_v[g]),
      .data     (data_v[g]),
      .ack      (ack_v[g]),
      .grant    (grant_v[g]),
      .tx_req   (tx_req_v[g]),
      .tx_data  (tx_data_v[g]),
      .tx_ready (tx_ready_v[g])
    );
  end

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src [4][8];
  int         src_len [4];
  int         src_pos [4];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_data(input bit sel, input int i, input logic [7:0] b);
    data_v[sel] = (data_v[sel] & ~(32'hFF << (8*i))) | ({24'h0, b} << (8*i));
  endtask

  task automatic load_req(input bit sel, input int i, input int len, input logic [63:0] bytes);
    logic [63:0] t;
    t = bytes;
    for (int k = 0; k < 8; k++) begin
      src[i][k] = t[7:0];
      t = t >> 8;
    end
    src_len[i] = len;
    src_pos[i] = 1;
    set_data(sel, i, src[i][0]);
    req_v[sel] = req_v[sel] | (4'b0001 << i);
  endtask

  task automatic advance(input bit sel, input int i);
    if (src_pos[i] < src_len[i]) begin
      set_data(sel, i, src[i][src_pos[i]]);
      src_pos[i]++;
    end else begin
      req_v[sel] = req_v[sel] & ~(4'b0001 << i);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] b);
    exp_t e;
    e.grant = 4'b0001 << id;
    e.data  = b;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 2; s++) begin
      req_v[s]      = '0;
      data_v[s]     = '0;
      tx_ready_v[s] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic check_reset(input bit sel);
    check_val("rst_grant", grant_v[sel], 0);
    check_val("rst_ack", ack_v[sel], 0);
    check_val("rst_tx_req", tx_req_v[sel], 0);
    check_val("rst_tx_data", tx_data_v[sel], 0);
  endtask

  // uart_tx model plus requester model; takes each byte lat cycles after tx_req.
  task automatic run_sb(input bit sel, input int lat, input int budget);
    int   cyc;
    int   wait_c;
    bit   pend_ack;
    logic [3:0] exp_ack;
    exp_t e;
    cyc = 0; wait_c = 0; pend_ack = 1'b0; exp_ack = '0;
    while ((exp_q.size() != 0 || pend_ack) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pend_ack) begin
        tx_ready_v[sel] = 1'b0;
        check_val("sb_ack", ack_v[sel], exp_ack);
        check_val("sb_txreq_after", tx_req_v[sel], 0);
        pend_ack = 1'b0;
        for (int i = 0; i < 4; i++)
          if (((ack_v[sel] >> i) & 4'b0001) != 4'b0000) advance(sel, i);
      end else begin
        if (ack_v[sel] != 4'b0000) check_val("sb_ack_spurious", ack_v[sel], 0);
        if (tx_req_v[sel]) begin
          wait_c++;
          if (wait_c >= lat) begin
            e = exp_q.pop_front();
            check_val("sb_grant", grant_v[sel], e.grant);
            check_val("sb_tx_data", tx_data_v[sel], e.data);
            tx_ready_v[sel] = 1'b1;
            pend_ack = 1'b1;
            exp_ack  = e.grant;
            wait_c   = 0;
          end
        end
      end
    end
    if (exp_q.size() != 0 || pend_ack)
      check_val("sb_timeout", 32'(exp_q.size()) + 32'(pend_ack), 0);
    tx_ready_v[sel] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("sb_end_grant", grant_v[sel], 0);
    check_val("sb_end_tx_req", tx_req_v[sel], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_reset(1'b0);
    check_reset(1'b1);
    reset_ = 1'b1;

    // Single requester, slow uart_tx.
    @(negedge clk);
    load_req(1'b0, 2, 1, 64'h41);
    @(negedge clk);
    check_val("single_grant", grant_v[0], 4'b0100);
    check_val("single_tx_req", tx_req_v[0], 1);
    check_val("single_tx_data", tx_data_v[0], 8'h41);
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      check_val("single_hold", {tx_req_v[0], tx_data_v[0]}, {1'b1, 8'h41});
      check_val("single_no_ack", ack_v[0], 0);
    end
    tx_ready_v[0] = 1'b1;
    @(negedge clk);
    tx_ready_v[0] = 1'b0;
    check_val("single_ack", ack_v[0], 4'b0100);
    check_val("single_tx_req_off", tx_req_v[0], 0);
    check_val("single_data_kept", tx_data_v[0], 8'h41);
    req_v[0] = '0;
    @(negedge clk);
    check_val("single_ack_once", ack_v[0], 0);
    @(negedge clk);
    check_val("single_release", grant_v[0], 0);

    // tx_ready while idle must be ignored.
    do_reset();
    @(negedge clk);
    tx_ready_v[0] = 1'b1;
    @(negedge clk);
    tx_ready_v[0] = 1'b0;
    check_val("idle_ready_ack", ack_v[0], 0);
    check_val("idle_ready_tx_req", tx_req_v[0], 0);

    // Contention without line lock: 0,1,3,0,1,3.
    do_reset();
    load_req(1'b1, 0, 2, 64'h1110);
    load_req(1'b1, 1, 2, 64'h2120);
    load_req(1'b1, 3, 2, 64'h3130);
    push_exp(0, 8'h10); push_exp(1, 8'h20); push_exp(3, 8'h30);
    push_exp(0, 8'h11); push_exp(1, 8'h21); push_exp(3, 8'h31);
    run_sb(1'b1, 3, 400);

    // Line lock: "AB\n" from 0 while 1 waits.
    do_reset();
    load_req(1'b0, 0, 3, 64'h0A4241);
    load_req(1'b0, 1, 1, 64'h5A);
    push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h0A); push_exp(1, 8'h5A);
    run_sb(1'b0, 2, 400);

    // Burst limit of 4 with no line feed.
    do_reset();
    load_req(1'b0, 0, 6, 64'h666564636261);
    load_req(1'b0, 1, 1, 64'h5A);
    push_exp(0, 8'h61); push_exp(0, 8'h62); push_exp(0, 8'h63); push_exp(0, 8'h64);
    push_exp(1, 8'h5A); push_exp(0, 8'h65); push_exp(0, 8'h66);
    run_sb(1'b0, 1, 400);

    // Requester drops req during SEND.
    do_reset();
    load_req(1'b0, 1, 1, 64'h77);
    @(negedge clk);
    check_val("drop_grant", grant_v[0], 4'b0010);
    req_v[0] = '0;
    repeat (3) begin
      @(negedge clk);
      check_val("drop_hold", {tx_req_v[0], tx_data_v[0]}, {1'b1, 8'h77});
    end
    tx_ready_v[0] = 1'b1;
    @(negedge clk);
    tx_ready_v[0] = 1'b0;
    check_val("drop_ack", ack_v[0], 4'b0010);
    check_val("drop_tx_req_off", tx_req_v[0], 0);
    @(negedge clk);
    check_val("drop_idle_grant", grant_v[0], 0);
    check_val("drop_idle_ack", ack_v[0], 0);

    // Async reset mid-SEND, then requester 0 must win over 3.
    do_reset();
    load_req(1'b0, 2, 1, 64'h78);
    push_exp(2, 8'h78);
    run_sb(1'b0, 1, 100);
    @(negedge clk);
    load_req(1'b0, 3, 1, 64'h33);
    @(negedge clk);
    check_val("ares_pre_grant", grant_v[0], 4'b1000);
    check_val("ares_pre_tx_req", tx_req_v[0], 1);
    #2;
    reset_ = 1'b0;
    #1;
    check_val("ares_tx_req", tx_req_v[0], 0);
    check_val("ares_grant", grant_v[0], 0);
    check_val("ares_ack", ack_v[0], 0);
    @(negedge clk);
    clear_inputs();
    reset_ = 1'b1;
    load_req(1'b0, 3, 1, 64'h33);
    load_req(1'b0, 0, 1, 64'h30);
    push_exp(0, 8'h30); push_exp(3, 8'h33);
    run_sb(1'b0, 2, 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
